cat_door_controller: RTL and testbench
======================================

# cat_door_controller

Sequential controller for the cat-flap door that wraps the combinational cat selector. Accepts one cat-attribute record at a time over a valid/ready handshake, presents it to the selector from registers, and samples the selector's verdict one cycle later. An approved cat opens the door for a timed window (extended while obstructed), followed by a cooldown. Accept and reject counts are kept for the status logic.

## Interface
Parameters:
- OPEN_CYCLES, 4, cycles DoorOpen stays high with no obstruction (≥1)
- COOLDOWN_CYCLES, 2, cycles after door close before a new record is accepted (≥1)
- COUNT_WIDTH, 8, width of AcceptCount/RejectCount

Ports:
- Clk  input  1  system clock; one clock domain
- Reset  input  1  synchronous, active-high reset
- CatValid  input  1  attribute record valid
- CatReady  output  1  controller can take a record; equals (state == IDLE)
- IsBlack, IsRed, IsSterilized, IsMale  input  1 each  attribute record
- SelIsBlack, SelIsRed, SelIsSterilized, SelIsMale  output  1 each  registered attributes driving the external cat_selector
- SelIsMyCat  input  1  cat_selector verdict (IsMyCat), combinational from Sel* outputs
- Obstructed  input  1  door sensor; holds the door open
- ClearCounts  input  1  synchronous clear of both counters
- DoorOpen  output  1  door actuator, registered
- Rejected  output  1  one-cycle pulse on a rejected record, registered
- Busy  output  1  state != IDLE
- AcceptCount  output  COUNT_WIDTH  approved cats, saturating
- RejectCount  output  COUNT_WIDTH  rejected cats, saturating

## Operation
- States: IDLE, EVAL, OPEN, COOLDOWN. Internal down-counter `timer` is wide enough for max(OPEN_CYCLES, COOLDOWN_CYCLES)−1.
- IDLE: CatReady=1. Handshake fires at an edge where CatValid=1 and CatReady=1. On fire: Sel* ← Is*, go EVAL. CatValid is ignored in all other states, and no record is buffered.
- EVAL (exactly 1 cycle): at the next edge, sample SelIsMyCat.
  - If 1: DoorOpen←1, timer←OPEN_CYCLES−1, AcceptCount+1, go OPEN.
  - If 0: Rejected←1, RejectCount+1, go IDLE.
- OPEN: at each edge:
  - If Obstructed=1, timer holds.
  - Else if timer==0: DoorOpen←0, timer←COOLDOWN_CYCLES−1, go COOLDOWN.
  - Else timer−1.
- COOLDOWN: at each edge, if timer==0 go IDLE, else timer−1. Obstructed is ignored.
- Rejected is high only in the cycle after EVAL; otherwise 0.
- Sel* hold their value until the next handshake.
- Counters saturate at 2^COUNT_WIDTH−1 and never wrap. ClearCounts=1 zeroes both at the edge and wins over a coincident increment.
- Reset (any state, including mid-OPEN): state←IDLE, DoorOpen←0, Rejected←0, Sel*←0, timer←0, counts←0. Reset dominates ClearCounts and the handshake.

## Timing
- Reset values after the reset edge: CatReady=1, Busy=0, DoorOpen=0, Rejected=0, Sel*=0, AcceptCount=0, RejectCount=0.
- Handshake at edge t0 → EVAL during t0..t1 → verdict sampled at t1.
- Accept path:
  - DoorOpen high from t1 to t1+OPEN_CYCLES+(obstructed cycles).
  - CatReady low for 1+OPEN_CYCLES+COOLDOWN_CYCLES+(obstructed cycles) cycles.
- Reject path:
  - CatReady low exactly 1 cycle.
  - Rejected high t1..t2.
  - Next handshake is possible at t2.
- Counter update is visible the cycle after t1.
- Obstructed high on the edge where timer==0 keeps the door open; close happens at the first edge with timer==0 and Obstructed=0.

## Test plan
Defaults: OPEN_CYCLES=4, COOLDOWN_CYCLES=2. The bench models the selector as SelIsMyCat = SelIsBlack & SelIsRed & SelIsSterilized & ~SelIsMale, or drives it directly.
- Reset: hold Reset 2 cycles with CatValid=1 → CatReady=1, Busy=0, DoorOpen=0, Sel*=0, counts=0, and no handshake taken.
- Accept: record black=1, red=1, sterilized=1, male=0 → during EVAL Sel*=1,1,1,0; DoorOpen high exactly 4 cycles starting the cycle after EVAL; CatReady low 7 cycles; AcceptCount=1; Rejected never asserted.
- Reject: record black=0, red=1, sterilized=0, male=1 → Rejected 1-cycle pulse, RejectCount=1, DoorOpen stays 0, CatReady low exactly 1 cycle. A back-to-back second record is accepted at the next edge.
- Obstruction: during an accepted cat, raise Obstructed for 3 cycles in OPEN, including the timer==0 cycle → DoorOpen high 7 cycles total, then 2 cooldown cycles. Obstructed asserted during COOLDOWN has no effect.
- Saturation and clear (COUNT_WIDTH=2): 5 accepted cats → AcceptCount=3 (no wrap). Then ClearCounts coincident with a sixth accept → AcceptCount=0 after that edge.
- Reset mid-operation: assert Reset in the 2nd OPEN cycle → DoorOpen=0 and CatReady=1 after that edge, counts=0. A following record is handled normally from IDLE.

Source files
------------

// File: rtl/cat_door_controller.sv
// Cat-flap door controller: takes one attribute record per handshake, drives the
// external selector from registers, then runs the open/cooldown door sequence.
module cat_door_controller #(
  parameter int OPEN_CYCLES     = 4,
  parameter int COOLDOWN_CYCLES = 2,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   CatValid,
  output logic                   CatReady,
  input  logic                   IsBlack,
  input  logic                   IsRed,
  input  logic                   IsSterilized,
  input  logic                   IsMale,
  output logic                   SelIsBlack,
  output logic                   SelIsRed,
  output logic                   SelIsSterilized,
  output logic                   SelIsMale,
  input  logic                   SelIsMyCat,
  input  logic                   Obstructed,
  input  logic                   ClearCounts,
  output logic                   DoorOpen,
  output logic                   Rejected,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] AcceptCount,
  output logic [COUNT_WIDTH-1:0] RejectCount
);

  localparam int MAXC = (OPEN_CYCLES > COOLDOWN_CYCLES) ? OPEN_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OPEN, S_COOLDOWN} state_t;

  // Handshake: a record is taken at an edge where CatValid && CatReady; CatReady
  // is high only in IDLE and nothing is buffered, so CatValid elsewhere is dropped.
  state_t                 r_state, w_state_nxt;
  logic [TW-1:0]          r_timer, w_timer_nxt;
  logic                   r_door_open, w_door_nxt;
  logic                   r_rejected, w_rej_nxt;
  logic [3:0]             r_sel;
  logic                   w_load_sel;
  logic                   w_acc_inc, w_rej_inc;
  logic [COUNT_WIDTH-1:0] r_acc_cnt, w_acc_nxt;
  logic [COUNT_WIDTH-1:0] r_rej_cnt, w_rej_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_door_nxt  = r_door_open;
    w_rej_nxt   = 1'b0;
    w_load_sel  = 1'b0;
    w_acc_inc   = 1'b0;
    w_rej_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CatValid) begin
          w_load_sel  = 1'b1;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (SelIsMyCat) begin
          w_door_nxt  = 1'b1;
          w_timer_nxt = TW'(OPEN_CYCLES - 1);
          w_acc_inc   = 1'b1;
          w_state_nxt = S_OPEN;
        end else begin
          w_rej_nxt   = 1'b1;
          w_rej_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_OPEN: begin
        // An obstruction freezes the timer, so the window restarts nothing but
        // simply stretches by the number of obstructed cycles.
        if (!Obstructed) begin
          if (r_timer == '0) begin
            w_door_nxt  = 1'b0;
            w_timer_nxt = TW'(COOLDOWN_CYCLES - 1);
            w_state_nxt = S_COOLDOWN;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
      end
      S_COOLDOWN: begin
        if (r_timer == '0) w_state_nxt = S_IDLE;
        else               w_timer_nxt = r_timer - TW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_nxt     = r_acc_cnt;
    w_rej_cnt_nxt = r_rej_cnt;
    if (ClearCounts) begin
      w_acc_nxt     = '0;
      w_rej_cnt_nxt = '0;
    end else begin
      if (w_acc_inc && (r_acc_cnt != CNT_MAX)) w_acc_nxt     = r_acc_cnt + COUNT_WIDTH'(1);
      if (w_rej_inc && (r_rej_cnt != CNT_MAX)) w_rej_cnt_nxt = r_rej_cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_door_open <= 1'b0;
      r_rejected  <= 1'b0;
      r_sel       <= '0;
      r_acc_cnt   <= '0;
      r_rej_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_door_open <= w_door_nxt;
      r_rejected  <= w_rej_nxt;
      r_acc_cnt   <= w_acc_nxt;
      r_rej_cnt   <= w_rej_cnt_nxt;
      if (w_load_sel) r_sel <= {IsBlack, IsRed, IsSterilized, IsMale};
    end
  end

  assign CatReady        = (r_state == S_IDLE);
  assign Busy            = (r_state != S_IDLE);
  assign DoorOpen        = r_door_open;
  assign Rejected        = r_rejected;
  assign SelIsBlack      = r_sel[3];
  assign SelIsRed        = r_sel[2];
  assign SelIsSterilized = r_sel[1];
  assign SelIsMale       = r_sel[0];
  assign AcceptCount     = r_acc_cnt;
  assign RejectCount     = r_rej_cnt;

endmodule

// File: tb/tb_cat_door_controller.sv
// Directed bench for cat_door_controller: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_cat_door_controller;

  localparam int OPEN_C = 4;
  localparam int COOL_C = 2;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int W      = 8 + 2 * CW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cat_valid, cat_ready;
  logic          is_black, is_red, is_ster, is_male;
  logic          sel_black, sel_red, sel_ster, sel_male, sel_my_cat;
  logic          obstructed, clear_counts, door_open, rejected, busy;
  logic [CW-1:0] accept_count, reject_count;

  // external selector model
  assign sel_my_cat = sel_black & sel_red & sel_ster & ~sel_male;

  cat_door_controller #(
    .OPEN_CYCLES(OPEN_C), .COOLDOWN_CYCLES(COOL_C), .COUNT_WIDTH(CW)
  ) dut (
    .Clk(clk), .Reset(reset), .CatValid(cat_valid), .CatReady(cat_ready),
    .IsBlack(is_black), .IsRed(is_red), .IsSterilized(is_ster), .IsMale(is_male),
    .SelIsBlack(sel_black), .SelIsRed(sel_red), .SelIsSterilized(sel_ster),
    .SelIsMale(sel_male), .SelIsMyCat(sel_my_cat), .Obstructed(obstructed),
    .ClearCounts(clear_counts), .DoorOpen(door_open), .Rejected(rejected),
    .Busy(busy), .AcceptCount(accept_count), .RejectCount(reject_count)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  logic [3:0]    exp_sel;
  logic [CW-1:0] exp_acc, exp_rej;
  logic          pend_rej;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (int'(x) == CMAX) ? x : x + CW'(1);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {cat_ready, busy, door_open, rejected,
            sel_black, sel_red, sel_ster, sel_male, accept_count, reject_count};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got rdy/busy/door/rej/sel/acc/rejc=%b expected %b",
                 nm, $time, a, e);
      end
    end
  end

  // driver tasks: each cyc() records this cycle's expected outputs, then advances one edge
  task automatic cyc(input logic rdy, input logic bsy, input logic door,
                     input logic rej, input string nm);
    exp_q.push_back({rdy, bsy, door, rej, exp_sel, exp_acc, exp_rej});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    cat_valid = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, pend_rej, nm);
    pend_rej = 1'b0;
  endtask

  // One record from IDLE. Obstructed is raised on OPEN cycles
  // [obs_first, obs_first+obs_cnt) and during cooldown if obs_cool.
  task automatic run_record(input logic [3:0] rec, input int obs_first, input int obs_cnt,
                            input logic obs_cool, input logic noisy, input logic clr,
                            input int rst_at, input string nm);
    int n_open;
    cat_valid = 1'b1;
    {is_black, is_red, is_ster, is_male} = rec;
    cyc(1'b1, 1'b0, 1'b0, pend_rej, {nm, "_hs"});
    pend_rej = 1'b0;
    exp_sel = rec;
    cat_valid = noisy;
    {is_black, is_red, is_ster, is_male} = ~rec;
    clear_counts = clr;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, {nm, "_eval"});
    clear_counts = 1'b0;
    if (rec == 4'b1110) begin
      exp_acc = clr ? '0 : sat_inc(exp_acc);
      if (clr) exp_rej = '0;
      n_open = OPEN_C + obs_cnt;
      for (int i = 0; i < n_open; i++) begin
        obstructed = (i >= obs_first) && (i < obs_first + obs_cnt);
        if (i == rst_at) reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, {nm, "_open"});
        if (i == rst_at) begin
          reset = 1'b0;
          obstructed = 1'b0;
          cat_valid = 1'b0;
          exp_sel = '0;
          exp_acc = '0;
          exp_rej = '0;
          return;
        end
      end
      obstructed = obs_cool;
      for (int i = 0; i < COOL_C; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, {nm, "_cool"});
      obstructed = 1'b0;
    end else begin
      exp_rej = clr ? '0 : sat_inc(exp_rej);
      if (clr) exp_acc = '0;
      pend_rej = 1'b1;
    end
    cat_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cat_valid = 1'b1;
    {is_black, is_red, is_ster, is_male} = 4'b1110;
    obstructed = 1'b0; clear_counts = 1'b0;
    exp_sel = '0; exp_acc = '0; exp_rej = '0; pend_rej = 1'b0;
    @(posedge clk);
    #1;
    // reset held with CatValid high: nothing taken
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset1");
    reset = 1'b0; cat_valid = 1'b0;
    idle("post_reset");

    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "accept");
    idle("idle_a");
    // reject followed by a back-to-back accept taken in the Rejected cycle
    run_record(4'b0101, 0, 0, 1'b0, 1'b0, 1'b0, -1, "reject");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "b2b_accept");
    // obstruction over the timer==0 cycle, noise on CatValid, obstruction in cooldown
    run_record(4'b1110, 3, 3, 1'b1, 1'b1, 1'b0, -1, "obstruct");
    idle("idle_o");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "sat4");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "sat5");
    idle("sat_acc");
    run_record(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0, -1, "rej2");
    run_record(4'b0110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "rej3");
    run_record(4'b1010, 0, 0, 1'b0, 1'b0, 1'b0, -1, "rej_sat");
    idle("sat_rej");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b1, -1, "clr_accept");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "after_clr");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, 1, "mid_reset");
    idle("after_reset");
    run_record(4'b1110, 0, 0, 1'b0, 1'b0, 1'b0, -1, "post_rst_accept");
    run_record(4'b0001, 0, 0, 1'b0, 1'b0, 1'b0, -1, "final_reject");
    idle("final_idle");
    idle("final_idle2");

    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
